control_sequencer: RTL and testbench

- Hardwired control unit for the 32-bit bus-based CPU datapath.
- Sequences the datapath through fetch, decode and execute by driving the bus-source selects, register-enable strobes, the memory read/write and the ALU operation.
- Decodes IR[31:27] and runs one fixed micro-step sequence per instruction class.
- Sits beside the datapath. It takes IR contents and CON as inputs and produces every control strobe the datapath consumes.

---
 rtl/control_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control unit for the 32-bit bus-based CPU datapath: fetch, decode
// and per-class execute micro-steps, with a programmable memory wait.
module control_sequencer #(
   parameter int MEM_WAIT = 1
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] ir,
   input  logic        con,
   input  logic        stop,
   output logic        run,
   output logic        PCout,
   output logic        Zhighout,
   output logic        Zlowout,
   output logic        MDRout,
   output logic        HIout,
   output logic        LOout,
   output logic        InPortout,
   output logic        Cout,
   output logic        PCIn,
   output logic        IncPC,
   output logic        MARIn,
   output logic        MDRIn,
   output logic        IRIn,
   output logic        YIn,
   output logic        ZIn,
   output logic        HiIn,
   output logic        LoIn,
   output logic        OutIn,
   output logic        CONIn,
   output logic        read,
   output logic        write,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic [4:0]  alu_op
);

   typedef enum logic [3:0] {
      RST, T0, T1, FW, T2, T3, T4, T5, T6, T7, MW, HALT
   } state_t;

   typedef enum logic [3:0] {
      C_RTYPE, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_UNARY, C_BRANCH,
      C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
   } cls_t;

   localparam logic [4:0] OP_ADD    = 5'b00011;
   localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

   state_t      state, state_next;
   logic [3:0]  cnt, cnt_next;
   cls_t        cls;
   logic [4:0]  opcode;
   logic        last_step;
   logic        unused_ir;

   assign opcode    = ir[31:27];
   assign unused_ir = ^ir[26:0];

   always_comb begin
      case (opcode) inside
         5'd0:          cls = C_LD;
         5'd1:          cls = C_LDI;
         5'd2:          cls = C_ST;
         [5'd3:5'd11]:  cls = C_RTYPE;
         [5'd12:5'd14]: cls = C_IMM;
         [5'd15:5'd16]: cls = C_MULDIV;
         [5'd17:5'd18]: cls = C_UNARY;
         5'd19:         cls = C_BRANCH;
         5'd20:         cls = C_JR;
         5'd21:         cls = C_JAL;
         5'd22:         cls = C_IN;
         5'd23:         cls = C_OUT;
         5'd24:         cls = C_MFHI;
         5'd25:         cls = C_MFLO;
         5'd27:         cls = C_HALT;
         default:       cls = C_NOP;
      endcase
   end

   // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= RST;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // NOTE: every output and next-state variable gets a default first, so no latches.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      last_step  = 1'b0;
      run        = (state != RST) && (state != HALT);
      {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout} = '0;
      {PCIn, IncPC, MARIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn, OutIn, CONIn} = '0;
      {read, write, Gra, Grb, Grc, Rin, Rout, BAout} = '0;
      alu_op     = '0;

      case (state)
         RST:  state_next = T0;
         T0: begin
            PCout = 1'b1; MARIn = 1'b1; IncPC = 1'b1; ZIn = 1'b1;
            state_next = T1;
         end
         T1: begin
            Zlowout = 1'b1; PCIn = 1'b1; read = 1'b1;
            state_next = FW;
            cnt_next   = WAIT_LOAD;
         end
         FW: begin
            read = 1'b1;
            if (cnt == '0) begin
               MDRIn      = 1'b1;
               state_next = T2;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         T2: begin
            MDRout = 1'b1; IRIn = 1'b1;
            state_next = T3;
         end
         T3: begin
            state_next = T4;
            case (cls)
               C_RTYPE, C_IMM:     begin Grb = 1'b1; Rout = 1'b1; YIn = 1'b1; end
               C_LDI, C_LD, C_ST:  begin Grb = 1'b1; BAout = 1'b1; YIn = 1'b1; end
               C_MULDIV:           begin Gra = 1'b1; Rout = 1'b1; YIn = 1'b1; end
               C_UNARY: begin
                  Grb = 1'b1; Rout = 1'b1; ZIn = 1'b1; alu_op = opcode;
               end
               C_BRANCH:           begin Gra = 1'b1; Rout = 1'b1; CONIn = 1'b1; end
               C_JAL:              begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
               C_JR:   begin Gra = 1'b1; Rout = 1'b1; PCIn = 1'b1; last_step = 1'b1; end
               C_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1; end
               C_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutIn = 1'b1; last_step = 1'b1; end
               C_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1; end
               C_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1; end
               C_HALT: state_next = HALT;
               default: last_step = 1'b1;
            endcase
         end
         T4: begin
            state_next = T5;
            case (cls)
               C_RTYPE: begin Grc = 1'b1; Rout = 1'b1; ZIn = 1'b1; alu_op = opcode; end
               C_IMM:   begin Cout = 1'b1; ZIn = 1'b1; alu_op = opcode; end
               C_LDI, C_LD, C_ST: begin Cout = 1'b1; ZIn = 1'b1; alu_op = OP_ADD; end
               C_MULDIV: begin Grb = 1'b1; Rout = 1'b1; ZIn = 1'b1; alu_op = opcode; end
               C_UNARY: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1; end
               C_BRANCH: begin PCout = 1'b1; YIn = 1'b1; end
               C_JAL:   begin Gra = 1'b1; Rout = 1'b1; PCIn = 1'b1; last_step = 1'b1; end
               default: state_next = T0;
            endcase
         end
         T5: begin
            state_next = T6;
            case (cls)
               C_RTYPE, C_IMM, C_LDI: begin
                  Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1;
               end
               C_LD: begin
                  Zlowout = 1'b1; MARIn = 1'b1;
                  state_next = MW;
                  cnt_next   = WAIT_LOAD;
               end
               C_ST:     begin Zlowout = 1'b1; MARIn = 1'b1; end
               C_MULDIV: begin Zlowout = 1'b1; LoIn = 1'b1; end
               C_BRANCH: begin Cout = 1'b1; ZIn = 1'b1; alu_op = OP_ADD; end
               default:  state_next = T0;
            endcase
         end
         T6: begin
            case (cls)
               C_ST: begin
                  Gra = 1'b1; Rout = 1'b1; MDRIn = 1'b1;
                  state_next = MW;
                  cnt_next   = WAIT_LOAD;
               end
               C_MULDIV: begin Zhighout = 1'b1; HiIn = 1'b1; last_step = 1'b1; end
               C_BRANCH: begin Zlowout = 1'b1; PCIn = con; last_step = 1'b1; end
               default:  state_next = T0;
            endcase
         end
         MW: begin
            // Only ld and st reach the memory-wait state; ld reads, st writes.
            read  = (cls == C_LD);
            write = (cls == C_ST);
            if (cnt == '0) begin
               MDRIn = (cls == C_LD);
               if (cls == C_LD) state_next = T7;
               else             last_step  = 1'b1;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         T7: begin
            MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1;
         end
         HALT:    state_next = HALT;
         default: state_next = RST;
      endcase

      if (last_step) state_next = stop ? HALT : T0;
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (MEM_WAIT 1 and 3) checked cycle by
// cycle against per-instruction micro-step lists built from the instruction table.
module tb_control_sequencer;

   localparam logic [27:0] B_RUN  = 28'd1 << 27, B_PCOUT = 28'd1 << 26, B_ZHI   = 28'd1 << 25;
   localparam logic [27:0] B_ZLO  = 28'd1 << 24, B_MDROUT = 28'd1 << 23, B_HIOUT = 28'd1 << 22;
   localparam logic [27:0] B_LOOUT = 28'd1 << 21, B_INPORT = 28'd1 << 20, B_COUT = 28'd1 << 19;
   localparam logic [27:0] B_PCIN = 28'd1 << 18, B_INCPC = 28'd1 << 17, B_MARIN = 28'd1 << 16;
   localparam logic [27:0] B_MDRIN = 28'd1 << 15, B_IRIN = 28'd1 << 14, B_YIN  = 28'd1 << 13;
   localparam logic [27:0] B_ZIN  = 28'd1 << 12, B_HIIN = 28'd1 << 11, B_LOIN  = 28'd1 << 10;
   localparam logic [27:0] B_OUTIN = 28'd1 << 9, B_CONIN = 28'd1 << 8, B_READ  = 28'd1 << 7;
   localparam logic [27:0] B_WRITE = 28'd1 << 6, B_GRA  = 28'd1 << 5, B_GRB    = 28'd1 << 4;
   localparam logic [27:0] B_GRC  = 28'd1 << 3, B_RIN  = 28'd1 << 2, B_ROUT    = 28'd1 << 1;
   localparam logic [27:0] B_BAOUT = 28'd1;
   localparam logic [4:0]  ADD = 5'd3;

   typedef struct packed {
      logic [27:0] ctl;
      logic        chk_alu;
      logic [4:0]  alu;
   } step_t;

   step_t       exp_q[$];
   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        con = 1'b0;
   logic        stop = 1'b0;
   logic [31:0] ir = '0;
   logic        sel = 1'b0;
   int          cur_mw = 1;
   int          n_cmp = 0;
   int          n_bad = 0;

   wire [27:0]  obs [0:1];
   wire [4:0]   alu [0:1];
   logic [27:0] obs_sel;
   logic [4:0]  alu_sel;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      control_sequencer #(.MEM_WAIT(g == 0 ? 1 : 3)) u_dut (
         .clk(clk), .clr(clr), .ir(ir), .con(con), .stop(stop),
         .run(obs[g][27]), .PCout(obs[g][26]), .Zhighout(obs[g][25]), .Zlowout(obs[g][24]),
         .MDRout(obs[g][23]), .HIout(obs[g][22]), .LOout(obs[g][21]), .InPortout(obs[g][20]),
         .Cout(obs[g][19]), .PCIn(obs[g][18]), .IncPC(obs[g][17]), .MARIn(obs[g][16]),
         .MDRIn(obs[g][15]), .IRIn(obs[g][14]), .YIn(obs[g][13]), .ZIn(obs[g][12]),
         .HiIn(obs[g][11]), .LoIn(obs[g][10]), .OutIn(obs[g][9]), .CONIn(obs[g][8]),
         .read(obs[g][7]), .write(obs[g][6]), .Gra(obs[g][5]), .Grb(obs[g][4]),
         .Grc(obs[g][3]), .Rin(obs[g][2]), .Rout(obs[g][1]), .BAout(obs[g][0]),
         .alu_op(alu[g])
      );
   end

   always_comb begin
      obs_sel = sel ? obs[1] : obs[0];
      alu_sel = sel ? alu[1] : alu[0];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (MEM_WAIT=%0d)", tag, got, exp, cur_mw);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ctl"}, 32'(obs_sel), 32'd0);
      check({tag, "_alu"}, 32'(alu_sel), 32'd0);
   endtask

   function automatic void push(input logic [27:0] c, input logic chk = 1'b0,
                                input logic [4:0] a = 5'd0);
      step_t s;
      s.ctl = c | B_RUN;
      s.chk_alu = chk;
      s.alu = a;
      exp_q.push_back(s);
   endfunction

   function automatic void push_wait(input logic [27:0] strobe, input logic last_mdr);
      for (int k = 1; k <= cur_mw; k++)
         push(strobe | ((k == cur_mw && last_mdr) ? B_MDRIN : 28'd0));
   endfunction

   // Expected micro-steps for one whole instruction, fetch included.
   function automatic void build_seq(input logic [4:0] op, input logic c);
      exp_q.delete();
      push(B_PCOUT | B_MARIN | B_INCPC | B_ZIN);
      push(B_ZLO | B_PCIN | B_READ);
      push_wait(B_READ, 1'b1);
      push(B_MDROUT | B_IRIN);
      if (op >= 5'd3 && op <= 5'd14) begin
         push(B_GRB | B_ROUT | B_YIN);
         if (op <= 5'd11) push(B_GRC | B_ROUT | B_ZIN, 1'b1, op);
         else             push(B_COUT | B_ZIN, 1'b1, op);
         push(B_ZLO | B_GRA | B_RIN);
      end else if (op <= 5'd2) begin
         push(B_GRB | B_BAOUT | B_YIN);
         push(B_COUT | B_ZIN, 1'b1, ADD);
         if (op == 5'd1) push(B_ZLO | B_GRA | B_RIN);
         else begin
            push(B_ZLO | B_MARIN);
            if (op == 5'd0) begin
               push_wait(B_READ, 1'b1);
               push(B_MDROUT | B_GRA | B_RIN);
            end else begin
               push(B_GRA | B_ROUT | B_MDRIN);
               push_wait(B_WRITE, 1'b0);
            end
         end
      end else begin
         case (op)
            5'd15, 5'd16: begin
               push(B_GRA | B_ROUT | B_YIN);
               push(B_GRB | B_ROUT | B_ZIN, 1'b1, op);
               push(B_ZLO | B_LOIN);
               push(B_ZHI | B_HIIN);
            end
            5'd17, 5'd18: begin
               push(B_GRB | B_ROUT | B_ZIN, 1'b1, op);
               push(B_ZLO | B_GRA | B_RIN);
            end
            5'd19: begin
               push(B_GRA | B_ROUT | B_CONIN);
               push(B_PCOUT | B_YIN);
               push(B_COUT | B_ZIN, 1'b1, ADD);
               push(B_ZLO | (c ? B_PCIN : 28'd0));
            end
            5'd20: push(B_GRA | B_ROUT | B_PCIN);
            5'd21: begin
               push(B_PCOUT | B_GRB | B_RIN);
               push(B_GRA | B_ROUT | B_PCIN);
            end
            5'd22: push(B_INPORT | B_GRA | B_RIN);
            5'd23: push(B_GRA | B_ROUT | B_OUTIN);
            5'd24: push(B_HIOUT | B_GRA | B_RIN);
            5'd25: push(B_LOOUT | B_GRA | B_RIN);
            default: push(28'd0);
         endcase
      end
   endfunction

   task automatic do_reset();
      clr = 1'b0;
      #1 check_idle("reset_async");
      @(posedge clk); @(negedge clk);
      check_idle("reset_hold");
      clr = 1'b1;
      @(posedge clk); @(negedge clk);
   endtask

   // Entered at a negedge with the DUT in T0; leaves at the negedge after the
   // instruction (next T0 or HALT), or after an abort and fresh restart.
   task automatic run_instr(input logic [31:0] word, input logic c, input logic want_halt,
                            input int abort_at = -1);
      logic [4:0] op;
      int         n;
      op = word[31:27];
      build_seq(op, c);
      ir = word;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         stop = (i == n - 1) ? want_halt : 1'($urandom);
         con  = (i == n - 1 && op == 5'd19) ? c : 1'($urandom);
         #1;
         check($sformatf("op%0d_step%0d_ctl", op, i), 32'(obs_sel), 32'(exp_q[i].ctl));
         if (exp_q[i].chk_alu)
            check($sformatf("op%0d_step%0d_alu", op, i), 32'(alu_sel), 32'(exp_q[i].alu));
         if (i == abort_at) begin
            clr = 1'b0;
            #1 check_idle("abort_async");
            @(posedge clk); @(negedge clk);
            check_idle("abort_hold");
            clr = 1'b1;
            @(posedge clk); @(negedge clk);
            stop = 1'b0;
            return;
         end
         @(posedge clk); @(negedge clk);
      end
      stop = 1'b0;
   endtask

   task automatic halt_check(input string tag);
      for (int i = 0; i < 20; i++) begin
         stop = 1'($urandom);
         #1 check_idle($sformatf("%s_halt%0d", tag, i));
         @(posedge clk); @(negedge clk);
      end
      stop = 1'b0;
      do_reset();
   endtask

   task automatic random_run(input int count);
      logic [4:0] op;
      for (int i = 0; i < count; i++) begin
         op = 5'($urandom_range(0, 31));
         if (op == 5'd27) op = 5'd26;
         run_instr({op, 27'($urandom)}, 1'($urandom), 1'b0);
      end
   endtask

   task automatic suite();
      do_reset();
      run_instr({5'd3, 27'h0918000}, 1'b0, 1'b0);
      run_instr({5'd0, 27'($urandom)}, 1'b0, 1'b0);
      run_instr({5'd2, 27'($urandom)}, 1'b0, 1'b0);
      run_instr({5'd19, 27'($urandom)}, 1'b0, 1'b0);
      run_instr({5'd19, 27'($urandom)}, 1'b1, 1'b0);
      random_run(40);
      run_instr({5'd3, 27'($urandom)}, 1'b0, 1'b1);
      halt_check("stop");
      run_instr({5'd27, 27'($urandom)}, 1'b0, 1'b0);
      halt_check("haltop");
      run_instr({5'd15, 27'($urandom)}, 1'b0, 1'b0, 4 + cur_mw);
      run_instr({5'd26, 27'($urandom)}, 1'b0, 1'b0);
      run_instr({5'd16, 27'($urandom)}, 1'b0, 1'b0);
   endtask

   initial begin
      #2;
      sel = 1'b0; cur_mw = 1;
      suite();
      sel = 1'b1; cur_mw = 3;
      suite();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "time limit");
   end

endmodule
